// File: rtl/bldc_pkg.sv
// Shared types and helpers for the six-step BLDC commutator: FSM state
// encodings, hall-code decode and the sector-to-phase drive table.
package bldc_pkg;

   localparam logic [2:0] STATE_IDLE  = 3'd0;
   localparam logic [2:0] STATE_DEAD  = 3'd1;
   localparam logic [2:0] STATE_RUN   = 3'd2;
   localparam logic [2:0] STATE_BRAKE = 3'd3;
   localparam logic [2:0] STATE_FAULT = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = STATE_IDLE,
      ST_DEAD  = STATE_DEAD,
      ST_RUN   = STATE_RUN,
      ST_BRAKE = STATE_BRAKE,
      ST_FAULT = STATE_FAULT
   } state_t;

   typedef logic [2:0] sector_t;

   typedef struct packed {
      logic    valid;
      sector_t sector;
   } hall_dec_t;

   typedef struct packed {
      logic [2:0] hi;
      logic [2:0] lo;
   } pattern_t;

   // One-hot phase masks in {R,S,T} bit order
   localparam logic [2:0] PH_R = 3'b100;
   localparam logic [2:0] PH_S = 3'b010;
   localparam logic [2:0] PH_T = 3'b001;

   function automatic hall_dec_t hall_to_sector(input logic [2:0] code);
      hall_dec_t d;
      d.valid  = 1'b1;
      d.sector = 3'd0;
      case (code)
         3'b101:  d.sector = 3'd0;
         3'b100:  d.sector = 3'd1;
         3'b110:  d.sector = 3'd2;
         3'b010:  d.sector = 3'd3;
         3'b011:  d.sector = 3'd4;
         3'b001:  d.sector = 3'd5;
         default: d.valid  = 1'b0;
      endcase
      return d;
   endfunction

   // Reverse rotation drives the pattern three sectors ahead
   function automatic pattern_t sector_pattern(input sector_t sector, input logic dir);
      sector_t  s;
      pattern_t p;
      s = sector;
      if (dir) s = (sector >= 3'd3) ? sector - 3'd3 : sector + 3'd3;
      p.hi = 3'b000;
      p.lo = 3'b000;
      case (s)
         3'd0: begin p.hi = PH_R; p.lo = PH_S; end
         3'd1: begin p.hi = PH_R; p.lo = PH_T; end
         3'd2: begin p.hi = PH_S; p.lo = PH_T; end
         3'd3: begin p.hi = PH_S; p.lo = PH_R; end
         3'd4: begin p.hi = PH_T; p.lo = PH_R; end
         3'd5: begin p.hi = PH_T; p.lo = PH_S; end
         default: ;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/bldc_hall_filter.sv
// Hall input synchronizer plus stability filter: a new code is accepted only
// after HALL_FILT consecutive identical synchronized samples.
module bldc_hall_filter
   import bldc_pkg::*;
#(
   parameter int HALL_FILT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] hall,
   output logic [2:0] code,
   output logic       changed
);

   localparam int CW = $clog2(HALL_FILT + 1);
   localparam logic [CW-1:0] RUN_MAX = CW'(HALL_FILT);

   logic [2:0]    sync1_q, sync2_q, last_q, code_q, code_d;
   logic [CW-1:0] run_q, run_d;
   logic          changed_q, changed_d;

   always_comb begin
      run_d     = CW'(1);
      code_d    = code_q;
      changed_d = 1'b0;
      if (sync2_q == last_q) run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      if (run_d == RUN_MAX && sync2_q != code_q) begin
         code_d    = sync2_q;
         changed_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 3'b000;
         sync2_q   <= 3'b000;
         last_q    <= 3'b000;
         run_q     <= '0;
         code_q    <= 3'b000;
         changed_q <= 1'b0;
      end else begin
         sync1_q   <= hall;
         sync2_q   <= sync1_q;
         last_q    <= sync2_q;
         run_q     <= run_d;
         code_q    <= code_d;
         changed_q <= changed_d;
      end
   end

   assign code    = code_q;
   assign changed = changed_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step hall-commutated gate controller: PWM chops the active high side,
// every pattern change passes through an all-off dead interval.
module bldc_commutator
   import bldc_pkg::*;
#(
   parameter int PWM_BITS     = 8,
   parameter int DEAD_CYCLES  = 27,
   parameter int HALL_FILT    = 4,
   parameter int STALL_CYCLES = 2_700_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                dir,
   input  logic                brake,
   input  logic [PWM_BITS-1:0] duty,
   input  logic [2:0]          hall,
   output logic [2:0]          hin,
   output logic [2:0]          lin_n,
   output logic [2:0]          state,
   output logic                fault
);

   localparam int DEAD_W  = $clog2(DEAD_CYCLES + 1);
   localparam int STALL_W = $clog2(STALL_CYCLES + 1);
   localparam logic [DEAD_W-1:0]   DEAD_LOAD  = DEAD_W'(DEAD_CYCLES - 1);
   localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(STALL_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] PWM_TOP    = PWM_BITS'((1 << PWM_BITS) - 2);

   logic [2:0]          hall_code;
   logic                hall_changed;
   hall_dec_t           dec;
   pattern_t            pat;
   logic                pwm_on;

   state_t              state_q, state_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
   logic [DEAD_W-1:0]   dead_q, dead_d;
   logic [STALL_W-1:0]  stall_q, stall_d;
   sector_t             run_sector_q, run_sector_d;
   logic                run_dir_q, run_dir_d, dir_q;
   logic [2:0]          hin_q, hin_d, lin_n_q, lin_n_d;
   logic                fault_q, fault_d;

   bldc_hall_filter #(.HALL_FILT(HALL_FILT)) u_hall_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .hall    (hall),
      .code    (hall_code),
      .changed (hall_changed)
   );

   // RUN drives from the sector/dir latched at DEAD expiry, so a fresh hall
   // code can never reach the gates without first passing through DEAD.
   assign dec    = hall_to_sector(hall_code);
   assign pat    = sector_pattern(run_sector_q, run_dir_q);
   assign pwm_on = (pwm_cnt_q < duty_q);

   always_comb begin
      pwm_cnt_d = (pwm_cnt_q == PWM_TOP) ? '0 : pwm_cnt_q + 1'b1;
      duty_d    = (pwm_cnt_q == '0) ? duty : duty_q;
   end

   always_comb begin
      state_d      = state_q;
      dead_d       = dead_q;
      stall_d      = '0;
      run_sector_d = run_sector_q;
      run_dir_d    = run_dir_q;
      if (state_q != ST_FAULT && !enable) begin
         state_d = ST_IDLE;
      end else if ((state_q == ST_DEAD || state_q == ST_RUN || state_q == ST_BRAKE) && !dec.valid) begin
         state_d = ST_FAULT;
      end else if (state_q == ST_RUN && duty_q != '0 && stall_q >= STALL_LAST) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable && dec.valid) begin
                  state_d = ST_DEAD;
                  dead_d  = DEAD_LOAD;
               end
            end
            ST_DEAD: begin
               if (hall_changed || dir != dir_q) begin
                  dead_d = DEAD_LOAD;
               end else if (dead_q == '0) begin
                  state_d      = brake ? ST_BRAKE : ST_RUN;
                  run_sector_d = dec.sector;
                  run_dir_d    = dir;
               end else begin
                  dead_d = dead_q - 1'b1;
               end
            end
            ST_RUN: begin
               if (dec.sector != run_sector_q || dir != run_dir_q || brake) begin
                  state_d = ST_DEAD;
                  dead_d  = DEAD_LOAD;
               end else if (duty_q != '0 && stall_q != {STALL_W{1'b1}}) begin
                  stall_d = stall_q + 1'b1;
               end else begin
                  stall_d = stall_q;
               end
            end
            ST_BRAKE: begin
               if (!brake) begin
                  state_d = ST_DEAD;
                  dead_d  = DEAD_LOAD;
               end
            end
            ST_FAULT: begin
               if (!enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      hin_d   = 3'b000;
      lin_n_d = 3'b111;
      fault_d = (state_d == ST_FAULT);
      case (state_q)
         ST_RUN: begin
            hin_d   = pat.hi & {3{pwm_on}};
            lin_n_d = ~pat.lo;
         end
         ST_BRAKE: lin_n_d = 3'b000;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pwm_cnt_q    <= '0;
         duty_q       <= '0;
         dead_q       <= '0;
         stall_q      <= '0;
         run_sector_q <= 3'd0;
         run_dir_q    <= 1'b0;
         dir_q        <= 1'b0;
         hin_q        <= 3'b000;
         lin_n_q      <= 3'b111;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pwm_cnt_q    <= pwm_cnt_d;
         duty_q       <= duty_d;
         dead_q       <= dead_d;
         stall_q      <= stall_d;
         run_sector_q <= run_sector_d;
         run_dir_q    <= run_dir_d;
         dir_q        <= dir;
         hin_q        <= hin_d;
         lin_n_q      <= lin_n_d;
         fault_q      <= fault_d;
      end
   end

   assign hin   = hin_q;
   assign lin_n = lin_n_q;
   assign state = state_q;
   assign fault = fault_q;

endmodule

// File: doc/bldc_commutator.md
# bldc_commutator

Hall-sensor-driven six-step commutation controller for the three-phase gate driver on the Tang Nano 9K brushless board. Sits between the switch/control logic (enable, direction, brake, duty) and the `HIN_x` / `_LIN_x` gate pins. It filters the hall inputs, selects the conducting phase pair, PWM-chops the high side, inserts dead time on every pattern change, and latches faults on bad hall codes or stall.

## Interface
- `PWM_BITS`, 8: duty and PWM counter width.
- `DEAD_CYCLES`, 27: all-off cycles inserted before any new drive pattern (1 µs at 27 MHz).
- `HALL_FILT`, 4: consecutive identical synchronized samples required to accept a hall code.
- `STALL_CYCLES`, 2_700_000: cycles in RUN without a sector change before a stall fault (100 ms).

- `clk` in 1: system clock, 27 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; level-sensitive.
- `dir` in 1: 0 = forward, 1 = reverse.
- `brake` in 1: low-side brake request.
- `duty` in PWM_BITS: high-side on-time per PWM period.
- `hall` in 3: raw asynchronous hall inputs `{A,B,C}`.
- `hin` out 3: high-side gate drive `{R,S,T}`, active-high.
- `lin_n` out 3: low-side gate drive `{R,S,T}`, active-low.
- `state` out 3: current FSM state encoding.
- `fault` out 1: high while in FAULT.

## Operation
- Hall path:
  - 2-FF synchronizer.
  - Filter: the accepted code updates only after `HALL_FILT` consecutive identical synchronized samples.
- Sector decode of the accepted code: 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. Codes 000 and 111 are invalid.
- Forward pattern (high phase / low phase) per sector: 0 R/S, 1 R/T, 2 S/T, 3 S/R, 4 T/R, 5 T/S.
  - Reverse uses sector+3 mod 6.
  - The third phase is off on both sides.
- PWM:
  - Counter runs 0..2^PWM_BITS−2 and wraps, giving a period of 2^PWM_BITS−1 cycles.
  - `duty` is sampled into `duty_q` when the counter is 0.
  - `pwm_on = cnt < duty_q`; duty 0 means never on, duty max means always on.
  - Only the active high-side is chopped; the active low-side is held on for the whole sector.
- FSM states: IDLE=0, DEAD=1, RUN=2, BRAKE=3, FAULT=4.
  - IDLE: all off. Go to DEAD when `enable` is high and the code is valid.
  - DEAD: all off; counter loads `DEAD_CYCLES`. On expiry go to BRAKE if `brake`, else RUN.
  - RUN: drive the table pattern. Go to DEAD when the sector changes, `dir` changes, or `brake` rises.
  - BRAKE: all `hin`=0, all `lin_n`=0. Go to DEAD when `brake` falls.
  - FAULT: all off, sticky. Go to IDLE only when `enable` is low.
- Priorities, evaluated every cycle, highest first:
  1. `enable`=0 in any non-FAULT state: go to IDLE immediately, outputs off next cycle, no dead time needed.
  2. Invalid accepted code in DEAD, RUN or BRAKE: go to FAULT.
  3. Stall: go to FAULT.
  4. Normal transitions.
- Stall counter:
  - Counts in RUN while `duty_q` ≠ 0.
  - Clears on sector change or on leaving RUN.
  - Reaching `STALL_CYCLES` triggers FAULT.
  - Saturating; width `$clog2(STALL_CYCLES+1)`.
- A sector or `dir` change during DEAD reloads the dead counter.
- Invariant: `hin[i]`=1 and `lin_n[i]`=0 are never true simultaneously for any i, in any cycle.

## Timing
- Reset values:
  - `hin`=000, `lin_n`=111, `state`=IDLE, `fault`=0.
  - PWM counter 0, `duty_q` 0, accepted hall code 000 (invalid).
- All outputs are registered; no combinational path from any input to any output.
- Hall latency: a raw change stable from cycle k is accepted at cycle k+2+`HALL_FILT`. FSM enters DEAD the next cycle, outputs go off the cycle after.
- A new pattern appears exactly `DEAD_CYCLES` cycles after outputs went all-off.
- `enable` deassert: outputs all-off 2 cycles later (1 sample + 1 output register).
- Reset mid-operation: outputs go to reset values asynchronously, with no dead-time wait.

## Structure
- Package `bldc_pkg` contains:
  - `state_t` enum.
  - `sector_t` (3-bit).
  - Function `hall_to_sector` (returns valid flag plus sector).
  - Function `sector_pattern` (sector, dir → high-phase and low-phase one-hot).
  - Localparam encodings of the states.
- Sub-module `bldc_hall_filter`: synchronizer plus `HALL_FILT` stability filter; outputs the accepted code and a 1-cycle `changed` pulse.
- The PWM counter, dead counter, stall counter and FSM stay in `bldc_commutator`.

## Test plan
- Reset, then enable=1, hall=101, duty=128, dir=0 → 27 cycles all-off, then `hin`=100 chopped at 128/255, `lin_n`=101, state=RUN.
- Step hall through 101→100→110→010→011→001 → `lin_n`/`hin` follow the table, with exactly 27 all-off cycles at each change; the invariant is checked every cycle by assertion.
- Hall glitch to 100 for 3 cycles while in sector 0 → no change in output pattern.
- Hall forced to 111 for ≥`HALL_FILT` cycles while in RUN → `fault`=1 and all off. enable=0 → IDLE, `fault`=0.
- Hold hall constant with duty=64 and STALL_CYCLES overridden to 1000 → FAULT at cycle 1000 of RUN. With duty=0, no fault.
- brake=1 while in RUN → DEAD for 27 cycles, then `hin`=000, `lin_n`=000. brake=0 → DEAD, then RUN pattern resumes.
